// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one uart_tx between NREQ requesters, with
// per-requester lock for back-to-back characters and a start watchdog.
module uart_tx_arb #(
    parameter int NREQ = 4,
    parameter int WDOG = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   lock,
    input  logic [8*NREQ-1:0] data_in,
    output logic [NREQ-1:0]   gnt,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_ready,
    output logic [2:0]        owner,
    output logic              busy,
    output logic              err
);
    localparam int            CW       = (WDOG <= 15) ? 4 : $clog2(WDOG + 1);
    localparam logic [CW-1:0] WD_LIMIT = CW'(WDOG);
    localparam logic [CW-1:0] WD_MAX   = {CW{1'b1}};
    localparam logic [2:0]    LAST_RST = 3'(NREQ - 1);

    typedef enum logic [1:0] {IDLE, GRANT, WAIT_ACK, WAIT_DONE} state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [7:0]      data_q, data_d;
    logic            start_q, start_d;
    logic [2:0]      owner_q, owner_d;
    logic [2:0]      last_q, last_d;
    logic            busy_q, busy_d;
    logic            err_q, err_d;
    logic [CW-1:0]   wd_q, wd_d;
    logic [CW-1:0]   wd_inc;
    logic [2:0]      winner;

    // Requester vectors padded to the 3-bit index space of owner.
    logic [7:0]      req8;
    logic [7:0]      lock8;
    logic [63:0]     data64;

    assign req8   = 8'(req);
    assign lock8  = 8'(lock);
    assign data64 = 64'(data_in);

    function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] last);
        logic [2:0] pick;
        logic       found;
        int         idx;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = int'(last) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && r[3'(idx)]) begin
                pick  = 3'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        data_d  = data_q;
        wd_d    = wd_q;
        err_d   = err_q;
        wd_inc  = (wd_q == WD_MAX) ? wd_q : wd_q + 1'b1;
        winner  = rr_pick(req8, last_q);

        case (state_q)
            IDLE: begin
                if (tx_ready && (|req)) begin
                    owner_d = winner;
                    data_d  = data64[{winner, 3'b000} +: 8];
                    state_d = GRANT;
                end
            end
            GRANT: begin
                wd_d    = '0;
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (!tx_ready) begin
                    state_d = WAIT_DONE;
                end else begin
                    wd_d = wd_inc;
                    // Transmitter never took the character: drop it and flag.
                    if (wd_inc >= WD_LIMIT) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            WAIT_DONE: begin
                if (tx_ready) begin
                    if (lock8[owner_q] && req8[owner_q]) begin
                        data_d  = data64[{owner_q, 3'b000} +: 8];
                        state_d = GRANT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        start_d = (state_d == GRANT);
        for (int i = 0; i < NREQ; i++) begin
            gnt_d[i] = start_d && (owner_d == 3'(i));
        end
        if (start_d) last_d = owner_d;
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            data_q  <= 8'h00;
            start_q <= 1'b0;
            owner_q <= 3'd0;
            last_q  <= LAST_RST;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            data_q  <= data_d;
            start_q <= start_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            wd_q    <= wd_d;
        end
    end

    assign gnt      = gnt_q;
    assign tx_data  = data_q;
    assign tx_start = start_q;
    assign owner    = owner_q;
    assign busy     = busy_q;
    assign err      = err_q;
endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: transfer-level reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_uart_tx_arb;
    localparam int N        = 4;
    localparam int WD       = 15;
    localparam int UART_LEN = 11;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N-1:0]   lock;
    logic [8*N-1:0] data_in;
    logic [N-1:0]   gnt;
    logic [7:0]     tx_data;
    logic           tx_start;
    logic           tx_ready;
    logic [2:0]     owner;
    logic           busy;
    logic           err;

    uart_tx_arb #(.NREQ(N), .WDOG(WD)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .lock     (lock),
        .data_in  (data_in),
        .gnt      (gnt),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_ready (tx_ready),
        .owner    (owner),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 1'b0;
    int uart_mode = 0;    // 0 manual, 1 responsive transmitter, 2 stuck ready
    int u_cnt = 0;
    bit drop_on_gnt = 1'b1;
    int glog[$];
    int gaps[$];
    int gap_run = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, act, exp, $time);
    endtask

    function automatic bit bit_of(input logic [N-1:0] v, input int i);
        return ((int'(v) >> i) & 1) != 0;
    endfunction

    function automatic int qat(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    // Reference model: one character transfer at a time.
    bit         m_on, m_acked, m_start, m_err;
    int         m_own, m_last, m_wait;
    logic [7:0] m_data;

    function automatic int m_next_winner(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            if (bit_of(r, (last + k) % N)) return (last + k) % N;
        end
        return last;
    endfunction

    task automatic m_reset();
        m_on = 0; m_acked = 0; m_start = 0; m_err = 0;
        m_own = 0; m_last = N - 1; m_wait = 0; m_data = 8'h00;
    endtask

    task automatic m_begin(input int w);
        m_own   = w;
        m_last  = w;
        m_data  = 8'(data_in >> (8 * w));
        m_on    = 1;
        m_acked = 0;
        m_wait  = 0;
        m_start = 1;
    endtask

    task automatic m_step();
        bit was_start;
        was_start = m_start;
        m_start = 0;
        if (!m_on) begin
            if (tx_ready && req != '0) m_begin(m_next_winner(req, m_last));
        end else if (!was_start) begin
            if (!m_acked) begin
                if (!tx_ready) m_acked = 1;
                else begin
                    m_wait++;
                    if (m_wait >= WD) begin
                        m_err = 1;
                        m_on  = 0;
                    end
                end
            end else if (tx_ready) begin
                if (bit_of(lock, m_own) && bit_of(req, m_own)) m_begin(m_own);
                else m_on = 0;
            end
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) m_reset();
            else m_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("gnt", 32'(gnt), m_start ? (32'd1 << m_own) : 32'd0);
                chk("tx_start", 32'(tx_start), 32'(m_start));
                chk("tx_data", 32'(tx_data), 32'(m_data));
                chk("owner", 32'(owner), 32'(m_own));
                chk("busy", 32'(busy), 32'(m_on));
                chk("err", 32'(err), 32'(m_err));
            end
        end
    end

    // Requesters: log grants, optionally drop req, present a new character.
    initial begin
        forever begin
            @(negedge clk);
            if (gnt != '0) begin
                for (int i = 0; i < N; i++) begin
                    if (bit_of(gnt, i)) begin
                        glog.push_back(i);
                        if (drop_on_gnt) req = req & ~N'(1 << i);
                        data_in = data_in ^ (32'h5A << (8 * i));
                    end
                end
                gaps.push_back(gap_run);
                gap_run = 0;
            end else if (!busy) begin
                gap_run++;
            end
        end
    end

    // Transmitter: ready falls after tx_start and rises UART_LEN edges later.
    initial begin
        forever begin
            @(negedge clk);
            if (uart_mode == 1) begin
                if (tx_start) begin
                    tx_ready = 1'b0;
                    u_cnt = UART_LEN;
                end else if (!tx_ready) begin
                    u_cnt--;
                    if (u_cnt <= 0) tx_ready = 1'b1;
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic clear_logs();
        glog.delete();
        gaps.delete();
        gap_run = 0;
    endtask

    task automatic wait_gnts(input int n, input int budget, input string name);
        int c = 0;
        while (glog.size() < n && c < budget) begin
            @(negedge clk);
            #1;
            c++;
        end
        chk(name, 32'(glog.size() >= n), 32'd1);
    endtask

    task automatic wait_idle(input string name);
        int c = 0;
        do begin
            @(negedge clk);
            #1;
            c++;
        end while ((busy || !tx_ready) && c < 100);
        chk(name, 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int bc;
        rst = 1'b1;
        req = '0;
        lock = '0;
        data_in = 32'hD3_41_B1_A0;
        tx_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'h00);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        #1 rst = 1'b0;

        // Single request from requester 2.
        @(negedge clk);
        #1;
        uart_mode = 1;
        drop_on_gnt = 1'b1;
        req = 4'b0100;
        @(negedge clk);
        #1;
        chk("single_gnt", 32'(gnt), 32'b0100);
        chk("single_start", 32'(tx_start), 32'd1);
        chk("single_data", 32'(tx_data), 32'h41);
        chk("single_owner", 32'(owner), 32'd2);
        bc = busy ? 1 : 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #1;
            if (!busy) break;
            bc++;
        end
        chk("single_busy_len", 32'(bc), 32'd12);
        wait_idle("single_idle");

        // Contention from reset: full rotation then wrap.
        do_reset();
        #1;
        drop_on_gnt = 1'b0;
        clear_logs();
        req = 4'b1111;
        wait_gnts(5, 400, "rr_gnts");
        req = '0;
        chk("rr_0", 32'(qat(glog, 0)), 32'd0);
        chk("rr_1", 32'(qat(glog, 1)), 32'd1);
        chk("rr_2", 32'(qat(glog, 2)), 32'd2);
        chk("rr_3", 32'(qat(glog, 3)), 32'd3);
        chk("rr_4", 32'(qat(glog, 4)), 32'd0);
        wait_idle("rr_idle");

        // Lock: requester 1 keeps the channel back to back.
        do_reset();
        #1;
        clear_logs();
        lock = 4'b0010;
        req = 4'b0011;
        wait_gnts(4, 400, "lock_gnts");
        chk("lock_g0", 32'(qat(glog, 0)), 32'd0);
        chk("lock_g1", 32'(qat(glog, 1)), 32'd1);
        chk("lock_g2", 32'(qat(glog, 2)), 32'd1);
        chk("lock_g3", 32'(qat(glog, 3)), 32'd1);
        chk("lock_gap2", 32'(qat(gaps, 2)), 32'd0);
        chk("lock_gap3", 32'(qat(gaps, 3)), 32'd0);
        lock = '0;
        wait_gnts(5, 100, "unlock_gnt");
        chk("unlock_g4", 32'(qat(glog, 4)), 32'd0);
        chk("unlock_gap4", 32'(qat(gaps, 4)), 32'd1);
        req = '0;
        wait_idle("lock_idle");

        // Transmitter busy while a request is pending.
        uart_mode = 0;
        tx_ready = 1'b0;
        drop_on_gnt = 1'b1;
        clear_logs();
        req = 4'b0001;
        repeat (5) @(negedge clk);
        #1;
        chk("notready_nognt", 32'(glog.size()), 32'd0);
        chk("notready_busy", 32'(busy), 32'd0);
        tx_ready = 1'b1;
        uart_mode = 1;
        @(negedge clk);
        #1;
        chk("ready_start", 32'(tx_start), 32'd1);
        chk("ready_gnt", 32'(gnt), 32'b0001);
        wait_idle("ready_idle");

        // Watchdog: tx_ready never falls after the start pulse.
        uart_mode = 2;
        tx_ready = 1'b1;
        clear_logs();
        req = 4'b0100;
        wait_gnts(1, 20, "wd_gnt");
        repeat (15) @(negedge clk);
        #1;
        chk("wd_err_before", 32'(err), 32'd0);
        chk("wd_busy_before", 32'(busy), 32'd1);
        @(negedge clk);
        #1;
        chk("wd_err_after", 32'(err), 32'd1);
        chk("wd_busy_after", 32'(busy), 32'd0);
        uart_mode = 1;
        clear_logs();
        req = 4'b0010;
        wait_gnts(1, 20, "wd_next_gnt");
        chk("wd_next_owner", 32'(qat(glog, 0)), 32'd1);
        wait_idle("wd_next_idle");
        chk("wd_err_sticky", 32'(err), 32'd1);

        // Reset in the middle of a character.
        drop_on_gnt = 1'b0;
        clear_logs();
        req = 4'b1111;
        wait_gnts(1, 30, "mid_gnt");
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_gnt", 32'(gnt), 32'd0);
        chk("mid_rst_start", 32'(tx_start), 32'd0);
        chk("mid_rst_data", 32'(tx_data), 32'h00);
        chk("mid_rst_owner", 32'(owner), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        uart_mode = 0;
        tx_ready = 1'b1;
        clear_logs();
        @(negedge clk);
        #1;
        chk("mid_rst_hold_start", 32'(tx_start), 32'd0);
        #1 rst = 1'b0;
        uart_mode = 1;
        wait_gnts(1, 20, "post_rst_gnt");
        chk("post_rst_owner", 32'(qat(glog, 0)), 32'd0);
        req = '0;
        wait_idle("final_idle");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
